// File: rtl/shift_register_fifo.sv
// shift_register_fifo
// Elastic FIFO built from a reset-free, enable-gated shift chain (maps onto
// SRL primitives) plus a registered output stage. The oldest chain word is
// picked with a variable tap at entry ccnt-1. When the FIFO is empty, a new
// word bypasses the chain and goes straight into the output register.
// Total capacity is DEPTH chain entries plus the output register.

module shift_register_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH+2)-1:0]    count,
  output logic                          almost_full
);

  localparam int CNT_W = $clog2(DEPTH + 2);
  localparam int IDX_W = $clog2(DEPTH);

  // Shift chain storage. It has no reset, so synthesis can infer SRLs.
  logic [DATA_WIDTH-1:0] chain_q [DEPTH];

  logic [CNT_W-1:0]      ccnt_q, ccnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  s_ready_q, s_ready_d;
  logic                  almost_full_q, almost_full_d;

  logic                  load;
  logic                  push;
  logic                  chain_rd;
  logic                  chain_wr;
  logic                  bypass;
  logic [IDX_W-1:0]      tap_idx;

  // Handshake qualification and head-source selection for this cycle.
  // An empty chain lets an incoming word bypass it; otherwise the chain supplies the head.
  always_comb begin
    load     = !m_valid_q || m_ready;
    push     = s_valid && s_ready_q;
    chain_rd = load && (ccnt_q != '0);
    bypass   = load && (ccnt_q == '0) && push;
    chain_wr = push && !bypass;
    tap_idx  = '0;
    if (ccnt_q != '0) begin
      tap_idx = IDX_W'(ccnt_q - CNT_W'(1));
    end
  end

  // Next head word. The tap reads the chain before this edge's shift.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = chain_rd || bypass;
      if (chain_rd) begin
        m_data_d = chain_q[tap_idx];
      end else if (bypass) begin
        m_data_d = s_data;
      end
    end
  end

  // Occupancy bookkeeping. s_ready, count and almost_full are registered
  // from next-state values, so they never depend on same-cycle m_ready.
  always_comb begin
    ccnt_d        = ccnt_q + CNT_W'(chain_wr) - CNT_W'(chain_rd);
    count_d       = ccnt_d + CNT_W'(m_valid_d);
    s_ready_d     = ccnt_d < CNT_W'(DEPTH);
    almost_full_d = count_d >= CNT_W'(ALMOST_FULL);
  end

  // Shift chain: new word enters at entry 0 and older entries move up by one.
  always_ff @(posedge clk) begin
    if (chain_wr) begin
      chain_q[0] <= s_data;
      for (int i = 1; i < DEPTH; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  // Control and output registers. Asserting reset discards all words at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt_q        <= '0;
      count_q       <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      s_ready_q     <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      ccnt_q        <= ccnt_d;
      count_q       <= count_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      s_ready_q     <= s_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule
